conv_feed_scheduler: RTL
========================

// Module: conv_feed_scheduler
// PURPOSE
//  Sequences one convolution pass through the systolic MAC array.
//  - Validates the kernel/image configuration and pulses clear to the array.
//  - Drives the per-row FIFO read enables r_en with a one-cycle diagonal skew, for ramp-in and ramp-out.
//  - Stalls globally when an active FIFO is empty.
//  - Tags array results with a write address, then pulses done.
//  - Replaces the hand-sequenced r_en/clear/done stimulus used at top level.
// PARAMETERS
//  ARRAY_SIZE    9   number of array rows / FIFO lanes (flattened kernel taps)
//  DIM_DATA_SIZE 8   width of weight_size, image_height, image_width
//  ADDR_WIDTH    20  width of initial_address and out_addr
//  PIPE_LAT      9   cycles from last-lane FIFO read to its result at macout
// PORTS
//  s_clk           in   1              single clock, all logic on rising edge
//  reset           in   1              synchronous, active-high
//  start           in   1              begin a pass (sampled in IDLE only)
//  Weight_size     in   DIM_DATA_SIZE  kernel side K
//  image_height    in   DIM_DATA_SIZE  H
//  image_width     in   DIM_DATA_SIZE  W
//  initial_address in   ADDR_WIDTH     base result address
//  empty           in   ARRAY_SIZE     per-lane FIFO empty flags
//  r_en            out  ARRAY_SIZE     per-lane FIFO read enables
//  clear           out  1              array accumulator clear, one-cycle pulse
//  out_valid       out  1              macout holds a valid result this cycle
//  out_addr        out  ADDR_WIDTH     initial_address + result index
//  busy            out  1              high in every state except IDLE
//  done            out  1              one-cycle pulse at end of pass
//  cfg_err         out  1              one-cycle pulse on rejected start
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; counters 0. Reset mid-pass aborts immediately; done does not pulse.
//  - Config is latched at start. Derived values:
//    - L = K*K, the number of active lanes.
//    - N = (H-K+1)*(W-K+1), the number of result positions.
//    - N is computed as a 16-bit product; the tick counter t is 17 bits.
//  - Invalid config: K==0, K>H, K>W, or L>ARRAY_SIZE.
//    - start with invalid config pulses cfg_err for 1 cycle and stays in IDLE.
//  - FSM: IDLE -> CLEAR -> RUN -> FLUSH -> DONE -> IDLE.
//    - IDLE: start with valid config goes to CLEAR.
//    - CLEAR: 1 cycle with clear=1; t<=0; go to RUN.
//    - RUN, lane k wants to read when: k<L && k<=t && t<k+N.
//      - stall = any wanting lane has empty=1.
//      - Stall: r_en=0 on all lanes and t holds.
//      - No stall: r_en = want mask and t<=t+1.
//      - Go to FLUSH on the cycle with no stall and t==L-2+N (the last read is issued).
//      - Lanes >= L never assert r_en.
//    - FLUSH: r_en=0 for PIPE_LAT cycles, then go to DONE.
//    - DONE: done=1 for 1 cycle, then go to IDLE.
//  - Skew invariant: stalls freeze all lanes together, so lane k always reads 1 cycle after lane k-1 in t-space.
//  - Result tagging:
//    - A PIPE_LAT-deep shift register carries r_en[L-1] and shifts every cycle, stall or not.
//    - out_valid is its output.
//    - out_addr starts at initial_address and increments by 1 after each out_valid cycle.
//    - Exactly N out_valid cycles occur per pass, all before done.
//  - start while busy is ignored. An empty flag is ignored for lanes not currently wanting to read.
// STRUCTURE
//  - Shared package conv_pkg holds the FSM state encoding (IDLE, CLEAR, RUN, FLUSH, DONE) and the widths for N and t.
//  - Sub-module conv_lane_window(k): compares t against k, L and N, and produces want[k].
//    - It is instantiated ARRAY_SIZE times.
//  - The top level holds the FSM, the t counter, the stall reduction, the result shift register and the address counter.
// TESTING
//  1. K=3, H=W=5, base 0, all FIFOs non-empty, start at cycle 0:
//     - clear at cycle 1.
//     - r_en over cycles 2..18: 001, 003, 007, ... 1ff at cycle 10, then 1fe, ... 100 at cycle 18.
//     - out_valid at cycles 19..27 with out_addr 0..8; done at cycle 28.
//  2. Same as 1, with empty[4]=1 for cycles 8..10:
//     - r_en=0 and t frozen for 3 cycles.
//     - Afterwards the ramp resumes with the same mask sequence; done at cycle 31.
//  3. K=2, H=4, W=3 (L=4, N=6):
//     - r_en[8:4] never assert; the full mask is 0x00f.
//     - 6 out_valid cycles; out_addr runs base .. base+5.
//  4. Invalid configs, each followed by start:
//     - K=4 (L=16>9), K=0, and K=6 with H=5.
//     - Each gives a cfg_err pulse, busy=0, and no r_en, clear or done.
//  5. reset asserted during RUN at t=5:
//     - Next cycle all outputs are 0 and the state is IDLE.
//     - A fresh start then reproduces test 1 exactly.
//  6. start pulsed again during RUN and FLUSH: ignored; exactly one done pulse.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types for the convolution feed scheduler: FSM state encoding and
// the widths of the result-position count N and the tick counter t.
package conv_pkg;

  localparam int N_WIDTH = 16;
  localparam int T_WIDTH = 17;

  typedef logic [N_WIDTH-1:0] count_n_t;
  typedef logic [T_WIDTH-1:0] tick_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Square of the kernel side. Any valid K is at most 3, so 16 bits is ample.
  function automatic count_n_t kernel_lanes(input count_n_t k);
    return count_n_t'(k * k);
  endfunction

  // Number of output positions along one image axis for kernel side k.
  function automatic count_n_t axis_positions(input count_n_t dim, input count_n_t k);
    return count_n_t'(dim - k + count_n_t'(1));
  endfunction

endpackage

// File: rtl/conv_feed_scheduler_if.sv
// Control/status bundle between the convolution feed scheduler and the
// surrounding datapath (FIFOs, MAC array, result memory).
interface conv_feed_scheduler_if #(
  parameter int ARRAY_SIZE    = 9,
  parameter int DIM_DATA_SIZE = 8,
  parameter int ADDR_WIDTH    = 20
);

  logic                     start;
  logic [DIM_DATA_SIZE-1:0] Weight_size;
  logic [DIM_DATA_SIZE-1:0] image_height;
  logic [DIM_DATA_SIZE-1:0] image_width;
  logic [ADDR_WIDTH-1:0]    initial_address;
  logic [ARRAY_SIZE-1:0]    empty;

  logic [ARRAY_SIZE-1:0]    r_en;
  logic                     clear;
  logic                     out_valid;
  logic [ADDR_WIDTH-1:0]    out_addr;
  logic                     busy;
  logic                     done;
  logic                     cfg_err;

  // Scheduler side.
  modport master (
    input  start, Weight_size, image_height, image_width, initial_address, empty,
    output r_en, clear, out_valid, out_addr, busy, done, cfg_err
  );

  // Datapath / controller side.
  modport slave (
    output start, Weight_size, image_height, image_width, initial_address, empty,
    input  r_en, clear, out_valid, out_addr, busy, done, cfg_err
  );

endinterface

// File: rtl/conv_lane_window.sv
// Read window of one FIFO lane: lane LANE reads during ticks
// LANE .. LANE+N-1, provided the lane is one of the L active kernel taps.
module conv_lane_window
  import conv_pkg::*;
#(
  parameter int LANE = 0
) (
  input  tick_t    t,
  input  count_n_t lanes,
  input  count_n_t positions,
  output logic     want
);

  localparam tick_t LANE_T = tick_t'(LANE);

  logic lane_active;
  logic started;
  logic not_finished;

  always_comb begin
    lane_active  = LANE_T < tick_t'(lanes);
    started      = LANE_T <= t;
    not_finished = t < (LANE_T + tick_t'(positions));
    want         = lane_active && started && not_finished;
  end

endmodule

// File: rtl/conv_feed_scheduler.sv
// Sequences one convolution pass through the systolic MAC array: config check,
// clear pulse, diagonally skewed FIFO reads with global stall, result tagging.
module conv_feed_scheduler
  import conv_pkg::*;
#(
  parameter int ARRAY_SIZE    = 9,
  parameter int DIM_DATA_SIZE = 8,
  parameter int ADDR_WIDTH    = 20,
  parameter int PIPE_LAT      = 9
) (
  input logic                  s_clk,
  input logic                  reset,
  conv_feed_scheduler_if.master bus
);

  localparam int FLUSH_W = $clog2(PIPE_LAT + 1);

  typedef logic [ARRAY_SIZE-1:0] lane_mask_t;
  typedef logic [FLUSH_W-1:0]    flush_cnt_t;

  // ---------------------------------------------------------------------------
  // Configuration decode (combinational on the live inputs, latched at start)
  // ---------------------------------------------------------------------------
  count_n_t   k_in;
  count_n_t   h_in;
  count_n_t   w_in;
  count_n_t   lanes_in;
  count_n_t   positions_in;
  tick_t      last_tick_in;
  lane_mask_t last_mask_in;
  logic       cfg_ok;

  always_comb begin
    k_in         = count_n_t'(bus.Weight_size);
    h_in         = count_n_t'(bus.image_height);
    w_in         = count_n_t'(bus.image_width);
    lanes_in     = kernel_lanes(k_in);
    positions_in = count_n_t'(axis_positions(h_in, k_in) * axis_positions(w_in, k_in));
    // The final read is issued by lane L-1 at tick (L-1)+(N-1).
    last_tick_in = tick_t'(lanes_in) + tick_t'(positions_in) - tick_t'(2);
    last_mask_in = lane_mask_t'(1) << (lanes_in - count_n_t'(1));
    cfg_ok       = (k_in != '0) &&
                   (k_in <= h_in) &&
                   (k_in <= w_in) &&
                   (lanes_in <= count_n_t'(ARRAY_SIZE));
  end

  // ---------------------------------------------------------------------------
  // Pass state
  // ---------------------------------------------------------------------------
  state_e     state;
  tick_t      t;
  count_n_t   lanes_q;
  count_n_t   positions_q;
  tick_t      last_tick_q;
  lane_mask_t last_mask_q;
  flush_cnt_t flush_cnt;
  logic       clear_q;
  logic       done_q;
  logic       cfg_err_q;
  logic       busy_q;

  // ---------------------------------------------------------------------------
  // Per-lane read windows and global stall
  // ---------------------------------------------------------------------------
  lane_mask_t want;
  logic       stall;
  logic       advance;
  logic       last_lane_read;

  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
    conv_lane_window #(
      .LANE (k)
    ) u_window (
      .t         (t),
      .lanes     (lanes_q),
      .positions (positions_q),
      .want      (want[k])
    );
  end

  // Reads must react to empty within the same cycle, so r_en is decoded from
  // registered state and the live empty flags rather than registered itself.
  // A stall freezes every lane together, which preserves the diagonal skew.
  always_comb begin
    stall          = |(want & bus.empty);
    advance        = (state == ST_RUN) && !stall;
    bus.r_en       = advance ? want : '0;
    last_lane_read = |(bus.r_en & last_mask_q);
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_clk) begin
    // NOTE: reset is sampled on the clock edge only; there is no asynchronous path.
    if (reset) begin
      state       <= ST_IDLE;
      t           <= '0;
      lanes_q     <= '0;
      positions_q <= '0;
      last_tick_q <= '0;
      last_mask_q <= '0;
      flush_cnt   <= '0;
      clear_q     <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; pulses default low and are set for one cycle.
      clear_q   <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              lanes_q     <= lanes_in;
              positions_q <= positions_in;
              last_tick_q <= last_tick_in;
              last_mask_q <= last_mask_in;
              clear_q     <= 1'b1;
              busy_q      <= 1'b1;
              state       <= ST_CLEAR;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end

        ST_CLEAR: begin
          t     <= '0;
          state <= ST_RUN;
        end

        ST_RUN: begin
          if (!stall) begin
            t <= t + 1'b1;
            if (t == last_tick_q) begin
              flush_cnt <= flush_cnt_t'(PIPE_LAT - 1);
              state     <= ST_FLUSH;
            end
          end
        end

        // Let the last reads travel through the array before signalling done.
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result tagging: a last-lane read emerges at macout PIPE_LAT cycles later,
  // independent of later stalls, so the delay line shifts every cycle.
  // ---------------------------------------------------------------------------
  logic [PIPE_LAT-1:0]   result_pipe;
  logic [ADDR_WIDTH-1:0] out_addr_q;

  always_ff @(posedge s_clk) begin
    if (reset) begin
      result_pipe <= '0;
    end else begin
      result_pipe <= {result_pipe[PIPE_LAT-2:0], last_lane_read};
    end
  end

  always_ff @(posedge s_clk) begin
    if (reset) begin
      out_addr_q <= '0;
    end else if ((state == ST_IDLE) && bus.start && cfg_ok) begin
      out_addr_q <= bus.initial_address;
    end else if (result_pipe[PIPE_LAT-1]) begin
      out_addr_q <= out_addr_q + 1'b1;
    end
  end

  assign bus.clear     = clear_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = result_pipe[PIPE_LAT-1];
  assign bus.out_addr  = out_addr_q;

endmodule
